// File: rtl/mux_tree_reduce_pipe_if.sv
// mux_tree_reduce_pipe_if: multi-lane upstream and single-lane downstream valid/ready bundle
interface mux_tree_reduce_pipe_if #(parameter int N = 8, parameter int W = 8);
  localparam int L = $clog2(N);
  logic up_valid;
  logic up_ready;
  logic [N*W-1:0] up_data;
  logic [1:0] up_mode;
  logic [L-1:0] up_sel;
  logic down_valid;
  logic down_ready;
  logic [W-1:0] down_data;
  modport slave (input up_valid, up_data, up_mode, up_sel, down_ready, output up_ready, down_valid, down_data);
  modport master (output up_valid, up_data, up_mode, up_sel, down_ready, input up_ready, down_valid, down_data);
endinterface

// File: rtl/mux_tree_reduce_pipe.sv
// mux_tree_reduce_pipe: pipelined N:1 MUX/OR/AND reduction tree, one register level per tree level;
// define MUX_TREE_XOR_EN to make mode 11 an XOR reduction (otherwise mode 11 yields zero)
module mux_tree_reduce_pipe #(parameter int N = 8, parameter int W = 8) (
  input logic clk,
  input logic rst,
  mux_tree_reduce_pipe_if.slave bus
);
  localparam int L = $clog2(N);
  logic [L-1:0] v, r;
  // every result bit is built from 2:1 muxes and the constants 0/1 only
  function automatic logic [W-1:0] red(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic [1:0] m, input logic s);
    logic [W-1:0] o;
    logic x;
    o = '0;
    for (int i = 0; i < W; i++) begin
`ifdef MUX_TREE_XOR_EN
      x = a[i] ? (b[i] ? 1'b0 : 1'b1) : b[i];
`else
      x = 1'b0;
`endif
      o[i] = m == 2'b00 ? (s ? b[i] : a[i]) : m == 2'b01 ? (a[i] ? 1'b1 : b[i]) :
             m == 2'b10 ? (a[i] ? b[i] : 1'b0) : x;
    end
    return o;
  endfunction
  // ready ripples back from the consumer so bubbles anywhere in the pipe can be filled
  always_comb begin
    logic acc;
    acc = bus.down_ready;
    r = '0;
    for (int s = L - 1; s >= 0; s--) begin
      acc = !v[s] | acc;
      r[s] = acc;
    end
  end
  for (genvar s = 0; s < L; s++) begin : stg
    localparam int K = N >> (s + 1);
    logic [2*K*W-1:0] din;
    logic [1:0] min;
    logic [L-s-1:0] sin;
    logic vin, vq;
    logic [K*W-1:0] q, nq;
    if (s == 0) begin : g_src
      assign din = bus.up_data;
      assign min = bus.up_mode;
      assign sin = bus.up_sel;
      assign vin = bus.up_valid;
    end else begin : g_src
      assign din = stg[s-1].q;
      assign min = stg[s-1].g_ctl.mq;
      assign sin = stg[s-1].g_ctl.sq;
      assign vin = v[s-1];
    end
    always_comb begin
      nq = '0;
      for (int j = 0; j < K; j++)
        nq[j*W +: W] = red(din[2*j*W +: W], din[(2*j+1)*W +: W], min, sin[0]);
    end
    always_ff @(posedge clk) begin
      if (rst) begin
        vq <= 1'b0;
        q <= '0;
      end else begin
        if (r[s]) vq <= vin;
        if (r[s] && vin) q <= nq;
      end
    end
    assign v[s] = vq;
    // mode and the unconsumed sel bits only travel on while a later level needs them
    if (s < L - 1) begin : g_ctl
      logic [1:0] mq;
      logic [L-s-2:0] sq;
      always_ff @(posedge clk) begin
        if (rst) begin
          mq <= '0;
          sq <= '0;
        end else if (r[s] && vin) begin
          mq <= min;
          sq <= sin[L-s-1:1];
        end
      end
    end
  end
  assign bus.up_ready = r[0];
  assign bus.down_valid = v[L-1];
  assign bus.down_data = stg[L-1].q;
endmodule

// File: tb/tb_mux_tree_reduce_pipe.sv
// tb_mux_tree_reduce_pipe: directed scoreboard bench for the N=8 tree plus an N=2 instance
module tb_mux_tree_reduce_pipe;
  typedef struct {
    logic [7:0] d;
    int t;
    bit lat;
  } exp_t;
  logic clk = 1'b0;
  logic rst;
  int vecs = 0;
  int errs = 0;
  int cyc = 0;
  bit chk_lat = 1'b1;
  bit stall = 1'b0;
  logic [7:0] held;
  exp_t sb[$];
  mux_tree_reduce_pipe_if #(.N(8), .W(8)) bus();
  mux_tree_reduce_pipe_if #(.N(2), .W(8)) bus2();
  mux_tree_reduce_pipe #(.N(8), .W(8)) dut (.clk(clk), .rst(rst), .bus(bus));
  mux_tree_reduce_pipe #(.N(2), .W(8)) dut2 (.clk(clk), .rst(rst), .bus(bus2));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic logic [7:0] ref_red(input logic [63:0] d, input logic [1:0] m, input logic [2:0] s);
    logic [7:0] o;
    int idx;
    idx = int'(s);
    o = (m == 2'b10) ? 8'hFF : 8'h00;
    if (m == 2'b00) o = d[idx*8 +: 8];
    else
      for (int k = 0; k < 8; k++) begin
        if (m == 2'b01) o = o | d[k*8 +: 8];
        if (m == 2'b10) o = o & d[k*8 +: 8];
`ifdef MUX_TREE_XOR_EN
        if (m == 2'b11) o = o ^ d[k*8 +: 8];
`endif
      end
    return o;
  endfunction
  task automatic send(input logic [63:0] d, input logic [1:0] m, input logic [2:0] s);
    bit ok;
    int t;
    bus.up_valid = 1'b1;
    bus.up_data = d;
    bus.up_mode = m;
    bus.up_sel = s;
    ok = 1'b0;
    t = 0;
    for (int n = 0; n < 200 && !ok; n++) begin
      @(negedge clk);
      ok = bus.up_ready;
      t = cyc;
      @(posedge clk);
      #1;
    end
    if (ok) sb.push_back('{ref_red(d, m, s), t, chk_lat});
    else check("accept_timeout", {63'd0, ok}, 64'd1);
  endtask
  task automatic drain();
    for (int i = 0; i < 100 && sb.size() != 0; i++) @(posedge clk);
    #1;
    check("drain", sb.size(), 0);
  endtask
  task automatic n2(input logic [1:0] m, input logic s, input logic [7:0] exp);
    bus2.up_valid = 1'b1;
    bus2.up_mode = m;
    bus2.up_sel = s;
    check("n2_up_ready", bus2.up_ready, 1);
    @(posedge clk);
    #1;
    bus2.up_valid = 1'b0;
    check("n2_down_valid", bus2.down_valid, 1);
    check("n2_down_data", bus2.down_data, exp);
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (rst) stall = 1'b0;
    else begin
      if (stall && bus.down_valid) check("hold_stable", bus.down_data, held);
      if (bus.down_valid && bus.down_ready) begin
        if (sb.size() == 0) check("spurious_valid", sb.size(), 1);
        else begin
          e = sb.pop_front();
          check("down_data", bus.down_data, e.d);
          if (e.lat) check("latency", cyc - e.t, 3);
        end
      end
      stall = bus.down_valid && !bus.down_ready;
      held = bus.down_data;
    end
  end
  initial begin
    logic [63:0] d;
    rst = 1'b1;
    bus.up_valid = 1'b0;
    bus.up_data = '0;
    bus.up_mode = '0;
    bus.up_sel = '0;
    bus.down_ready = 1'b1;
    bus2.up_valid = 1'b0;
    bus2.up_data = 16'h3CC3;
    bus2.up_mode = '0;
    bus2.up_sel = '0;
    bus2.down_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_down_valid", bus.down_valid, 0);
    check("rst_down_data", bus.down_data, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("up_ready_after_rst", bus.up_ready, 1);
    check("down_valid_after_rst", bus.down_valid, 0);
    for (int k = 0; k < 8; k++) d[k*8 +: 8] = 8'h10 + 8'(k);
    send(d, 2'b00, 3'd5);
    send(d, 2'b00, 3'd0);
    send(d, 2'b00, 3'd7);
    bus.up_valid = 1'b0;
    drain();
    d = {8'h80, {6{8'hFF}}, 8'h01};
    send(d, 2'b01, 3'd0);
    send(d, 2'b10, 3'd3);
    for (int k = 0; k < 8; k++) d[k*8 +: 8] = 8'(1 << k);
    send(d, 2'b01, 3'd6);
    send(d, 2'b10, 3'd1);
    send(d, 2'b11, 3'd0);
    send({8{8'hA5}}, 2'b10, 3'd2);
    send({8{8'hA5}}, 2'b01, 3'd4);
    bus.up_valid = 1'b0;
    drain();
    for (int i = 0; i < 16; i++) send({$urandom, $urandom}, 2'($urandom), 3'($urandom));
    bus.up_valid = 1'b0;
    drain();
    chk_lat = 1'b0;
    fork
      begin
        for (int i = 0; i < 12; i++) send({$urandom, $urandom}, 2'($urandom_range(0, 2)), 3'($urandom));
        bus.up_valid = 1'b0;
      end
      begin
        repeat (4) @(posedge clk);
        #1;
        bus.down_ready = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("bp_up_ready", bus.up_ready, 0);
        check("bp_in_flight", sb.size(), 3);
        @(posedge clk);
        #1;
        bus.down_ready = 1'b1;
      end
    join
    drain();
    chk_lat = 1'b1;
    bus.down_ready = 1'b0;
    for (int i = 0; i < 3; i++) send({$urandom, $urandom}, 2'b00, 3'($urandom));
    bus.up_valid = 1'b0;
    check("midflight_valid", bus.down_valid, 1);
    check("midflight_count", sb.size(), 3);
    rst = 1'b1;
    @(posedge clk);
    #1;
    sb.delete();
    rst = 1'b0;
    bus.down_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("post_rst_no_valid", bus.down_valid, 0);
    end
    check("post_rst_data", bus.down_data, 0);
    n2(2'b00, 1'b0, 8'hC3);
    n2(2'b00, 1'b1, 8'h3C);
    n2(2'b01, 1'b0, 8'hFF);
    n2(2'b10, 1'b1, 8'h00);
`ifdef MUX_TREE_XOR_EN
    n2(2'b11, 1'b0, 8'hFF);
`else
    n2(2'b11, 1'b0, 8'h00);
`endif
    @(posedge clk);
    #1;
    check("n2_idle", bus2.down_valid, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
